riscv_mem_arb: RTL and testbench

RISCV_MEM_ARB -- requirements
Module: riscv_mem_arb

---
 rtl/riscv_mem_arb_if.sv | 49 ++++
 rtl/riscv_mem_arb.sv | 193 +++++++++++++++++++
 tb/tb_riscv_mem_arb.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_arb_if.sv
// riscv_mem_arb_if -- bus bundle between the fetch/data ports, the arbiter
// and the single-port SRAM. The arbiter uses the slave view; the
// surrounding core/memory (or a bench) uses the master view.
`timescale 1ns/1ps
interface riscv_mem_arb_if #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
);
  // instruction fetch port
  logic                  I_REQ;
  logic [AWIDTH-1:0]     I_ADDR;
  logic                  I_GNT;
  logic                  I_RVALID;
  logic [DWIDTH-1:0]     I_RDATA;
  // data port
  logic                  D_REQ;
  logic                  D_WEN;
  logic [DWIDTH/8-1:0]   D_BE;
  logic [AWIDTH-1:0]     D_ADDR;
  logic [DWIDTH-1:0]     D_WDATA;
  logic                  D_GNT;
  logic                  D_RVALID;
  logic [DWIDTH-1:0]     D_RDATA;
  // single-port SRAM side
  logic                  MEM_CSN;
  logic                  MEM_WEN;
  logic [DWIDTH/8-1:0]   MEM_BE;
  logic [AWIDTH-1:0]     MEM_ADDR;
  logic [DWIDTH-1:0]     MEM_DOUT;
  logic [DWIDTH-1:0]     MEM_DI;

  modport slave (
    input  I_REQ, I_ADDR,
    input  D_REQ, D_WEN, D_BE, D_ADDR, D_WDATA,
    input  MEM_DI,
    output I_GNT, I_RVALID, I_RDATA,
    output D_GNT, D_RVALID, D_RDATA,
    output MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DOUT
  );

  modport master (
    output I_REQ, I_ADDR,
    output D_REQ, D_WEN, D_BE, D_ADDR, D_WDATA,
    output MEM_DI,
    input  I_GNT, I_RVALID, I_RDATA,
    input  D_GNT, D_RVALID, D_RDATA,
    input  MEM_CSN, MEM_WEN, MEM_BE, MEM_ADDR, MEM_DOUT
  );
endinterface

// File: rtl/riscv_mem_arb.sv
// riscv_mem_arb -- arbitrates an instruction-fetch port and a data port onto
// one single-port SRAM with 1-cycle read latency.
// Grants are combinational; read responses are routed back by a small
// NONE/PEND tracker that remembers which port owns the in-flight read.
// Build option: define RISCV_ARB_RR_EN for round-robin conflict resolution;
// without it the data port always wins a conflict.
`timescale 1ns/1ps
module riscv_mem_arb #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
) (
  input  logic           CLK,
  input  logic           RSTn,
  riscv_mem_arb_if.slave bus,
  output logic [31:0]    STALL_CNT
);

  localparam int BWIDTH = DWIDTH / 8;

  typedef enum logic [0:0] {
    RSP_NONE = 1'b0,
    RSP_PEND = 1'b1
  } rsp_state_e;

  // owner / last-granted encoding
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  rsp_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [DWIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DWIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [31:0]       stall_q, stall_d;

  logic              i_gnt;
  logic              d_gnt;
  logic              rd_grant;
  logic              i_rvalid;
  logic              d_rvalid;

`ifdef RISCV_ARB_RR_EN
  // Port granted most recently; reset value makes the first conflict go to I.
  logic              last_q, last_d;
`endif

  // Grant selection: single requester wins outright, conflicts resolved by policy.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!RSTn) begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
    end else if (bus.I_REQ && bus.D_REQ) begin
`ifdef RISCV_ARB_RR_EN
      if (last_q == OWN_D) begin
        i_gnt = 1'b1;
      end else begin
        d_gnt = 1'b1;
      end
`else
      d_gnt = 1'b1;
`endif
    end else begin
      i_gnt = bus.I_REQ;
      d_gnt = bus.D_REQ;
    end
  end

  assign bus.I_GNT = i_gnt;
  assign bus.D_GNT = d_gnt;

  // SRAM command mux: idle bus is fully zeroed so nothing leaks from an ungranted port.
  always_comb begin
    bus.MEM_CSN  = 1'b1;
    bus.MEM_WEN  = 1'b1;
    bus.MEM_BE   = {BWIDTH{1'b0}};
    bus.MEM_ADDR = {AWIDTH{1'b0}};
    bus.MEM_DOUT = {DWIDTH{1'b0}};
    case ({i_gnt, d_gnt})
      2'b10: begin
        bus.MEM_CSN  = 1'b0;
        bus.MEM_WEN  = 1'b1;
        bus.MEM_BE   = {BWIDTH{1'b0}};
        bus.MEM_ADDR = bus.I_ADDR;
        bus.MEM_DOUT = {DWIDTH{1'b0}};
      end
      2'b01: begin
        bus.MEM_CSN  = 1'b0;
        bus.MEM_WEN  = bus.D_WEN;
        bus.MEM_BE   = bus.D_BE;
        bus.MEM_ADDR = bus.D_ADDR;
        bus.MEM_DOUT = bus.D_WDATA;
      end
      default: begin
        bus.MEM_CSN  = 1'b1;
        bus.MEM_WEN  = 1'b1;
        bus.MEM_BE   = {BWIDTH{1'b0}};
        bus.MEM_ADDR = {AWIDTH{1'b0}};
        bus.MEM_DOUT = {DWIDTH{1'b0}};
      end
    endcase
  end

  // Response valids decode straight from the tracker flops (no extra logic depth).
  assign i_rvalid = (state_q == RSP_PEND) && (owner_q == OWN_I);
  assign d_rvalid = (state_q == RSP_PEND) && (owner_q == OWN_D);

  assign bus.I_RVALID = i_rvalid;
  assign bus.D_RVALID = d_rvalid;
  // Present SRAM data in the response cycle itself; hold the captured copy after.
  assign bus.I_RDATA  = i_rvalid ? bus.MEM_DI : i_rdata_q;
  assign bus.D_RDATA  = d_rvalid ? bus.MEM_DI : d_rdata_q;

  assign STALL_CNT = stall_q;

  // Next-state logic: response tracker, read-data capture and stall counter.
  always_comb begin
    // a fetch is always a read; a data access reads when D_WEN is high
    rd_grant  = i_gnt || (d_gnt && bus.D_WEN);
    state_d   = RSP_NONE;
    owner_d   = owner_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    stall_d   = stall_q;

    if (rd_grant) begin
      state_d = RSP_PEND;
      owner_d = d_gnt ? OWN_D : OWN_I;
    end else begin
      state_d = RSP_NONE;
      owner_d = owner_q;
    end

    if (i_rvalid) begin
      i_rdata_d = bus.MEM_DI;
    end else begin
      i_rdata_d = i_rdata_q;
    end

    if (d_rvalid) begin
      d_rdata_d = bus.MEM_DI;
    end else begin
      d_rdata_d = d_rdata_q;
    end

    // saturate rather than wrap so long stalls never read as short ones
    if (bus.I_REQ && !i_gnt && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

`ifdef RISCV_ARB_RR_EN
  // Round-robin pointer follows every grant, conflicting or not.
  always_comb begin
    last_d = last_q;
    if (i_gnt) begin
      last_d = OWN_I;
    end else if (d_gnt) begin
      last_d = OWN_D;
    end else begin
      last_d = last_q;
    end
  end
`endif

  // State registers; reset drops any in-flight response immediately.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= RSP_NONE;
      owner_q   <= OWN_I;
      i_rdata_q <= {DWIDTH{1'b0}};
      d_rdata_q <= {DWIDTH{1'b0}};
      stall_q   <= 32'd0;
`ifdef RISCV_ARB_RR_EN
      last_q    <= OWN_D;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      stall_q   <= stall_d;
`ifdef RISCV_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

endmodule

// File: tb/tb_riscv_mem_arb.sv
// tb_riscv_mem_arb -- directed bench for riscv_mem_arb: a vector table for the
// combinational grant/SRAM mux, then hand-written sequences for fetch, write/
// read-back, conflict arbitration and reset with a pending response.
`timescale 1ns/1ps
module tb_riscv_mem_arb;

  localparam int AW = 12;
  localparam int DW = 32;
`ifdef RISCV_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] stall_cnt;
  int          n_vec;
  int          n_err;

  riscv_mem_arb_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  riscv_mem_arb #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .CLK       (clk),
    .RSTn      (rst_n),
    .bus       (bus.slave),
    .STALL_CNT (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: word addressed, byte-enabled writes, read data the cycle after
  logic [31:0] sram [0:1023];
  always @(posedge clk) begin
    if (!bus.MEM_CSN) begin
      if (!bus.MEM_WEN) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.MEM_BE[b]) sram[bus.MEM_ADDR[11:2]][8*b +: 8] <= bus.MEM_DOUT[8*b +: 8];
        end
      end else begin
        bus.MEM_DI <= sram[bus.MEM_ADDR[11:2]];
      end
    end
  end

  typedef struct {
    logic        i_req;
    logic [11:0] i_addr;
    logic        d_req;
    logic        d_wen;
    logic [3:0]  d_be;
    logic [11:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_igt;
    logic        e_dgt;
    logic        e_csn;
    logic        e_wen;
    logic [3:0]  e_be;
    logic [11:0] e_addr;
    logic [31:0] e_dout;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.I_REQ   = 1'b0;
    bus.I_ADDR  = 12'h000;
    bus.D_REQ   = 1'b0;
    bus.D_WEN   = 1'b1;
    bus.D_BE    = 4'h0;
    bus.D_ADDR  = 12'h000;
    bus.D_WDATA = 32'h0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic d_access(input logic wen, input logic [3:0] be, input logic [11:0] addr,
                          input logic [31:0] wdata);
    bus.D_REQ   = 1'b1;
    bus.D_WEN   = wen;
    bus.D_BE    = be;
    bus.D_ADDR  = addr;
    bus.D_WDATA = wdata;
  endtask

  initial begin
    logic prev_i;
    logic exp_i;
    n_vec = 0;
    n_err = 0;
    for (int w = 0; w < 1024; w++) sram[w] = 32'h0;
    sram[4] = 32'h0050_0093;
    bus.MEM_DI = 32'h0;
    idle_inputs();
    rst_n = 1'b0;

    // ---- reset state: requests present but nothing granted ----
    bus.I_REQ = 1'b1;
    bus.D_REQ = 1'b1;
    #3;
    chk("rst_i_gnt",    32'(bus.I_GNT),    32'd0);
    chk("rst_d_gnt",    32'(bus.D_GNT),    32'd0);
    chk("rst_mem_csn",  32'(bus.MEM_CSN),  32'd1);
    chk("rst_i_rvalid", 32'(bus.I_RVALID), 32'd0);
    chk("rst_d_rvalid", 32'(bus.D_RVALID), 32'd0);
    chk("rst_i_rdata",  bus.I_RDATA,       32'd0);
    chk("rst_d_rdata",  bus.D_RDATA,       32'd0);
    chk("rst_stall",    stall_cnt,         32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // ---- table: combinational grant and SRAM command mux, no conflicts ----
    vecs[0] = '{1'b0, 12'h000, 1'b0, 1'b1, 4'h0, 12'h000, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 12'h000, 32'h0};
    vecs[1] = '{1'b1, 12'h010, 1'b0, 1'b0, 4'hF, 12'h3FC, 32'hA5A5_A5A5,
                1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 12'h010, 32'h0};
    vecs[2] = '{1'b1, 12'hFFC, 1'b0, 1'b1, 4'h3, 12'h123, 32'h5555_AAAA,
                1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 12'hFFC, 32'h0};
    vecs[3] = '{1'b0, 12'h7F0, 1'b1, 1'b0, 4'h5, 12'h200, 32'h1234_5678,
                1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 12'h200, 32'h1234_5678};
    vecs[4] = '{1'b0, 12'h444, 1'b1, 1'b1, 4'hF, 12'h204, 32'hCAFE_F00D,
                1'b0, 1'b1, 1'b0, 1'b1, 4'hF, 12'h204, 32'hCAFE_F00D};
    vecs[5] = '{1'b0, 12'h888, 1'b0, 1'b0, 4'hF, 12'h2F0, 32'hFFFF_FFFF,
                1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 12'h000, 32'h0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.I_REQ   = vecs[i].i_req;
      bus.I_ADDR  = vecs[i].i_addr;
      bus.D_REQ   = vecs[i].d_req;
      bus.D_WEN   = vecs[i].d_wen;
      bus.D_BE    = vecs[i].d_be;
      bus.D_ADDR  = vecs[i].d_addr;
      bus.D_WDATA = vecs[i].d_wdata;
      #1;
      chk($sformatf("v%0d_i_gnt", i),  32'(bus.I_GNT),   32'(vecs[i].e_igt));
      chk($sformatf("v%0d_d_gnt", i),  32'(bus.D_GNT),   32'(vecs[i].e_dgt));
      chk($sformatf("v%0d_csn", i),    32'(bus.MEM_CSN), 32'(vecs[i].e_csn));
      chk($sformatf("v%0d_wen", i),    32'(bus.MEM_WEN), 32'(vecs[i].e_wen));
      chk($sformatf("v%0d_be", i),     32'(bus.MEM_BE),  32'(vecs[i].e_be));
      chk($sformatf("v%0d_addr", i),   32'(bus.MEM_ADDR), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_dout", i),   bus.MEM_DOUT,     vecs[i].e_dout);
    end
    @(negedge clk);
    idle_inputs();

    // ---- instruction fetch with 1-cycle latency ----
    @(negedge clk);
    bus.I_REQ  = 1'b1;
    bus.I_ADDR = 12'h010;
    #1;
    chk("fetch_gnt",  32'(bus.I_GNT),    32'd1);
    chk("fetch_addr", 32'(bus.MEM_ADDR), 32'h010);
    @(negedge clk);
    bus.I_REQ = 1'b0;
    #1;
    chk("fetch_rvalid", 32'(bus.I_RVALID), 32'd1);
    chk("fetch_rdata",  bus.I_RDATA,       32'h0050_0093);
    chk("fetch_no_d",   32'(bus.D_RVALID), 32'd0);
    @(negedge clk);
    #1;
    chk("fetch_rvalid_off", 32'(bus.I_RVALID), 32'd0);
    chk("fetch_rdata_hold", bus.I_RDATA,       32'h0050_0093);

    // ---- data write, read-back, partial-byte write, read-back ----
    @(negedge clk);
    d_access(1'b0, 4'hF, 12'h100, 32'hDEAD_BEEF);
    #1;
    chk("wr_gnt",  32'(bus.D_GNT),   32'd1);
    chk("wr_wen",  32'(bus.MEM_WEN), 32'd0);
    chk("wr_dout", bus.MEM_DOUT,     32'hDEAD_BEEF);
    @(negedge clk);
    #1;
    chk("wr_no_rvalid", 32'(bus.D_RVALID), 32'd0);
    d_access(1'b1, 4'hF, 12'h100, 32'h0);
    #1;
    chk("rd_wen", 32'(bus.MEM_WEN), 32'd1);
    @(negedge clk);
    d_access(1'b0, 4'h2, 12'h100, 32'h0000_AA00);
    #1;
    chk("rd_rvalid", 32'(bus.D_RVALID), 32'd1);
    chk("rd_rdata",  bus.D_RDATA,       32'hDEAD_BEEF);
    chk("rd_i_quiet", 32'(bus.I_RVALID), 32'd0);
    @(negedge clk);
    d_access(1'b1, 4'hF, 12'h100, 32'h0);
    #1;
    chk("wr2_no_rvalid", 32'(bus.D_RVALID), 32'd0);
    chk("wr2_rdata_hold", bus.D_RDATA,       32'hDEAD_BEEF);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("rd2_rvalid", 32'(bus.D_RVALID), 32'd1);
    chk("rd2_rdata",  bus.D_RDATA,       32'hDEAD_AAEF);

    // ---- conflict: both ports requesting for 4 cycles ----
    apply_reset();
    prev_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.I_REQ  = 1'b1;
      bus.I_ADDR = 12'h010;
      d_access(1'b1, 4'hF, 12'h100, 32'h0);
      #1;
      exp_i = RR ? ((k % 2) == 0) : 1'b0;
      chk($sformatf("cf%0d_i_gnt", k), 32'(bus.I_GNT), 32'(exp_i));
      chk($sformatf("cf%0d_d_gnt", k), 32'(bus.D_GNT), 32'(!exp_i));
      if (k > 0) begin
        chk($sformatf("cf%0d_i_rvalid", k), 32'(bus.I_RVALID), 32'(prev_i));
        chk($sformatf("cf%0d_d_rvalid", k), 32'(bus.D_RVALID), 32'(!prev_i));
        if (prev_i) chk($sformatf("cf%0d_i_rdata", k), bus.I_RDATA, 32'h0050_0093);
        else        chk($sformatf("cf%0d_d_rdata", k), bus.D_RDATA, 32'hDEAD_AAEF);
      end
      prev_i = exp_i;
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("cf_stall", stall_cnt, RR ? 32'd2 : 32'd4);
    chk("cf_last_d_rvalid", 32'(bus.D_RVALID), 32'(!prev_i));

    // ---- reset with a read pending ----
    @(negedge clk);
    bus.I_REQ  = 1'b1;
    bus.I_ADDR = 12'h010;
    @(posedge clk);
    #1;
    chk("pend_rvalid", 32'(bus.I_RVALID), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstpend_rvalid", 32'(bus.I_RVALID), 32'd0);
    chk("rstpend_rdata",  bus.I_RDATA,       32'd0);
    chk("rstpend_gnt",    32'(bus.I_GNT),    32'd0);
    chk("rstpend_csn",    32'(bus.MEM_CSN),  32'd1);
    chk("rstpend_stall",  stall_cnt,         32'd0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_i_rvalid", k), 32'(bus.I_RVALID), 32'd0);
      chk($sformatf("post_rst%0d_d_rvalid", k), 32'(bus.D_RVALID), 32'd0);
    end
    chk("post_rst_stall", stall_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
